// File: rtl/trace_scan_scheduler_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | trace_sched_pkg : shared FSM state type and width helper for the trace   |
// | scan scheduler.                                  Revision: 1.0           |
// +--------------------------------------------------------------------------+
package trace_sched_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      EMIT = 2'd2,
      DONE = 2'd3
   } trace_sched_state_e;

   // ceil(log2(n)) but never below 1, so single-entry dimensions still get a bit
   function automatic int clog2_min1(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) begin
         r = r + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/trace_scan_scheduler_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | trace_scan_scheduler_if : valid/ready record stream toward trace writer. |
// |                                                  Revision: 1.0           |
// +--------------------------------------------------------------------------+
interface trace_scan_scheduler_if #(
   parameter int IW = 4,
   parameter int VW = 4
);
   logic          rec_valid;
   logic          rec_ready;
   logic [IW-1:0] rec_inst;
   logic [VW-1:0] rec_var;
   logic          rec_val;

   modport master (
      output rec_valid,
      output rec_inst,
      output rec_var,
      output rec_val,
      input  rec_ready
   );

   modport slave (
      input  rec_valid,
      input  rec_inst,
      input  rec_var,
      input  rec_val,
      output rec_ready
   );
endinterface
`default_nettype wire

// File: rtl/trace_scan_scheduler_idx_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | trace_idx_counter : nested instance/variable counters plus a flat index  |
// | kept in lockstep, so no multiplier is needed.     Revision: 1.0          |
// +--------------------------------------------------------------------------+
module trace_idx_counter #(
   parameter int INSTANCES = 10,
   parameter int VARS      = 10,
   parameter int IW        = 4,
   parameter int VW        = 4,
   parameter int KW        = 7
) (
   input  wire logic          clk,
   input  wire logic          rst,
   input  wire logic          i_clear,
   input  wire logic          i_advance,
   output logic [IW-1:0]      o_inst,
   output logic [VW-1:0]      o_var,
   output logic [KW-1:0]      o_k,
   output logic               o_last
);

   logic [IW-1:0] r_inst;
   logic [VW-1:0] r_var;
   logic [KW-1:0] r_k;
   logic          w_var_last;

   assign w_var_last = (r_var == VW'(VARS - 1));
   assign o_last     = w_var_last && (r_inst == IW'(INSTANCES - 1));
   assign o_inst     = r_inst;
   assign o_var      = r_var;
   assign o_k        = r_k;

   always_ff @(posedge clk) begin
      if (rst || i_clear) begin
         r_inst <= '0;
         r_var  <= '0;
         r_k    <= '0;
      end else if (i_advance) begin
         r_k <= o_last ? '0 : r_k + 1'b1;
         if (w_var_last) begin
            r_var  <= '0;
            r_inst <= o_last ? '0 : r_inst + 1'b1;
         end else begin
            r_var  <= r_var + 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/trace_scan_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | trace_scan_scheduler : snapshots INSTANCES x VARS signal bits and emits  |
// | one record per changed bit (or every bit) over a valid/ready stream.     |
// |                                                  Revision: 1.0           |
// +--------------------------------------------------------------------------+
module trace_scan_scheduler
   import trace_sched_pkg::*;
#(
   parameter int INSTANCES = 10,
   parameter int VARS      = 10
) (
   input  wire logic                       clk,
   input  wire logic                       rst,
   input  wire logic                       start,
   input  wire logic                       full_dump,
   input  wire logic [INSTANCES*VARS-1:0]  sig_in,
   trace_scan_scheduler_if.master          rec,
   output logic                            busy,
   output logic                            done
);

   localparam int N  = INSTANCES * VARS;
   localparam int IW = clog2_min1(INSTANCES);
   localparam int VW = clog2_min1(VARS);
   localparam int KW = clog2_min1(N);

   trace_sched_state_e r_state;
   logic [N-1:0]       r_snap;
   logic [N-1:0]       r_shadow;
   logic               r_mode_full;
   logic               r_first_pend;
   logic               r_busy;
   logic               r_done;
   logic               r_rec_valid;
   logic [IW-1:0]      r_rec_inst;
   logic [VW-1:0]      r_rec_var;
   logic               r_rec_val;

   logic [IW-1:0]      w_inst;
   logic [VW-1:0]      w_var;
   logic [KW-1:0]      w_k;
   logic               w_last;
   logic               w_clear;
   logic               w_advance;
   logic               w_hit;

   assign w_hit     = r_mode_full || (r_snap[w_k] != r_shadow[w_k]);
   assign w_clear   = (r_state == IDLE) && start;
   // In EMIT rec_valid is always high, so ready alone marks the handshake
   assign w_advance = ((r_state == SCAN) && !w_hit) ||
                      ((r_state == EMIT) && rec.rec_ready);

   trace_idx_counter #(
      .INSTANCES (INSTANCES),
      .VARS      (VARS),
      .IW        (IW),
      .VW        (VW),
      .KW        (KW)
   ) u_idx (
      .clk       (clk),
      .rst       (rst),
      .i_clear   (w_clear),
      .i_advance (w_advance),
      .o_inst    (w_inst),
      .o_var     (w_var),
      .o_k       (w_k),
      .o_last    (w_last)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_snap       <= '0;
         r_shadow     <= '0;
         r_mode_full  <= 1'b0;
         r_first_pend <= 1'b1;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_rec_valid  <= 1'b0;
         r_rec_inst   <= '0;
         r_rec_var    <= '0;
         r_rec_val    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_snap       <= sig_in;
                  r_mode_full  <= full_dump | r_first_pend;
                  r_first_pend <= 1'b0;
                  r_busy       <= 1'b1;
                  r_state      <= SCAN;
               end
            end
            SCAN: begin
               if (w_hit) begin
                  r_rec_inst  <= w_inst;
                  r_rec_var   <= w_var;
                  r_rec_val   <= r_snap[w_k];
                  r_rec_valid <= 1'b1;
                  r_state     <= EMIT;
               end else if (w_last) begin
                  r_done  <= 1'b1;
                  r_state <= DONE;
               end
            end
            EMIT: begin
               if (rec.rec_ready) begin
                  r_shadow[w_k] <= r_rec_val;
                  r_rec_valid   <= 1'b0;
                  if (w_last) begin
                     r_done  <= 1'b1;
                     r_state <= DONE;
                  end else begin
                     r_state <= SCAN;
                  end
               end
            end
            DONE: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign rec.rec_valid = r_rec_valid;
   assign rec.rec_inst  = r_rec_inst;
   assign rec.rec_var   = r_rec_var;
   assign rec.rec_val   = r_rec_val;
   assign busy          = r_busy;
   assign done          = r_done;

endmodule
`default_nettype wire
